// File: rtl/mc_payoff_accum_pkg.sv
// Shared types and helpers for the Monte Carlo payoff accumulator.
// Holds the FSM encoding, default widths and lane-code utility functions.
package mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_FINISH = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEF_W     = 32;
  localparam int DEF_FRAC  = 16;
  localparam int DEF_LANES = 5;

  // Legal codes are 0...01...1, including all-zero; v & (v+1) clears exactly those.
  function automatic logic is_thermo(input logic [31:0] v);
    logic [31:0] p;
    p = v + 32'd1;
    return (v & p) == 32'd0;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mc_payoff_accum_if.sv
// Lane/control inputs and price/status outputs of the payoff accumulator.
// master drives the lanes and control, slave is the accumulator.
interface mc_payoff_accum_if
  import mc_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LANES = DEF_LANES
);
  logic               start;
  logic [LANES-1:0]   mc_output_ctrl;
  logic               engine_done;
  logic               lane_valid;
  logic [LANES*W-1:0] lane_payoff;
  logic [W-1:0]       price_out;
  logic               price_valid;
  logic               busy;
  logic               short_run;
  logic               ctrl_err;

  modport master (
    output start, mc_output_ctrl, engine_done, lane_valid, lane_payoff,
    input  price_out, price_valid, busy, short_run, ctrl_err
  );

  modport slave (
    input  start, mc_output_ctrl, engine_done, lane_valid, lane_payoff,
    output price_out, price_valid, busy, short_run, ctrl_err
  );
endinterface

// File: rtl/mc_lane_select.sv
// Combinational lane acceptance: enabled lanes, lowest index first, capped at the
// remaining sample budget; zero latency, no backpressure (excess lanes are dropped).
module mc_lane_select
  import mc_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int BW    = 11,
  parameter int PW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] ctrl_i,
  input  logic [BW-1:0]    budget_i,
  output logic [LANES-1:0] mask_o,
  output logic [PW-1:0]    cnt_o
);

  logic [31:0] pre;

  // pre counts enabled lanes below i, so lane i fits only while pre < budget.
  always_comb begin
    pre    = '0;
    mask_o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (ctrl_i[i] && (pre < 32'(budget_i))) begin
        mask_o[i] = 1'b1;
      end
      pre = pre + 32'(ctrl_i[i]);
    end
  end

  assign cnt_o = PW'(popcount(32'(mask_o)));

endmodule

// File: rtl/mc_payoff_accum.sv
// Accumulates 2^LOG2_PATHS lane payoffs and emits their mean; price_valid two
// edges after the N-th sample. No backpressure: lanes past the budget are dropped.
module mc_payoff_accum
  import mc_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int FRAC       = DEF_FRAC,
  parameter int LOG2_PATHS = 10,
  parameter int LANES      = DEF_LANES
) (
  input  logic             clk,
  input  logic             rst,
  mc_payoff_accum_if.slave bus_if
);

  localparam int ACCW = W + LOG2_PATHS;
  localparam int CW   = LOG2_PATHS + 1;
  localparam int PW   = $clog2(LANES + 1);
  localparam logic [CW-1:0] N_SAMPLES = {1'b1, {LOG2_PATHS{1'b0}}};

  state_e          state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    price_q, price_d;
  logic            pvld_q, pvld_d;
  logic            short_q, short_d;
  logic            err_q, err_d;

  logic [CW-1:0]    budget;
  logic [LANES-1:0] sel_mask;
  logic [PW-1:0]    sel_cnt;
  logic [ACCW-1:0]  lane_sum;
  logic             take;

  assign budget = N_SAMPLES - cnt_q;
  assign take   = (state_q == ST_ACCUM) && bus_if.lane_valid;

  mc_lane_select #(
    .LANES (LANES),
    .BW    (CW),
    .PW    (PW)
  ) u_sel (
    .ctrl_i   (bus_if.mc_output_ctrl),
    .budget_i (budget),
    .mask_o   (sel_mask),
    .cnt_o    (sel_cnt)
  );

  // Operands are zero-extended to the accumulator width; the sum of accepted lanes
  // is bounded by budget * 2^W, so it always fits.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sel_mask[i]) begin
        lane_sum = lane_sum + ACCW'(bus_if.lane_payoff[i*W +: W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      price_q <= '0;
      pvld_q  <= 1'b0;
      short_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      price_q <= price_d;
      pvld_q  <= pvld_d;
      short_q <= short_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (bus_if.start) state_d = ST_ACCUM;
      ST_ACCUM:         if ((cnt_d == N_SAMPLES) || bus_if.engine_done) state_d = ST_FINISH;
      ST_FINISH:        state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    price_d = price_q;
    pvld_d  = pvld_q;
    short_d = short_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus_if.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          pvld_d  = 1'b0;
          short_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (take) begin
          acc_d = acc_q + lane_sum;
          cnt_d = cnt_q + CW'(sel_cnt);
          if (!is_thermo(32'(bus_if.mc_output_ctrl))) err_d = 1'b1;
        end
        // Samples in the done cycle land first; a run that just filled is not short.
        if (bus_if.engine_done && (cnt_d != N_SAMPLES)) short_d = 1'b1;
      end
      ST_FINISH: begin
        price_d = acc_q[LOG2_PATHS +: W];
        pvld_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus_if.busy        = (state_q == ST_ACCUM) || (state_q == ST_FINISH);
    bus_if.price_out   = price_q;
    bus_if.price_valid = pvld_q;
    bus_if.short_run   = short_q;
    bus_if.ctrl_err    = err_q;
  end

endmodule

// File: tb/tb_mc_payoff_accum.sv
// Directed bench for mc_payoff_accum with N=8 (LOG2_PATHS=3).
module tb_mc_payoff_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mc_payoff_accum_if #(.W(32), .LANES(5)) bus_if ();

  mc_payoff_accum #(
    .W          (32),
    .FRAC       (16),
    .LOG2_PATHS (3),
    .LANES      (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                           input logic [31:0] l3, input logic [31:0] l4);
    bus_if.lane_payoff = {l4, l3, l2, l1, l0};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (bus_if.price_out !== 32'h0) begin n_err++; $display("FAIL reset_price: got %h want 0", bus_if.price_out); end
    n_cmp++; if (bus_if.price_valid !== 1'b0) begin n_err++; $display("FAIL reset_pvld: got %b want 0", bus_if.price_valid); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.short_run !== 1'b0) begin n_err++; $display("FAIL reset_short: got %b want 0", bus_if.short_run); end
    n_cmp++; if (bus_if.ctrl_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus_if.ctrl_err); end
    // Lane traffic in IDLE must not flag a bad control code.
    bus_if.mc_output_ctrl = 5'b00101;
    bus_if.lane_valid = 1'b1;
    tick();
    tick();
    bus_if.lane_valid = 1'b0;
    n_cmp++; if (bus_if.ctrl_err !== 1'b0) begin n_err++; $display("FAIL idle_err: got %b want 0", bus_if.ctrl_err); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", bus_if.busy); end
  endtask

  task automatic test_single_lane();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL single_busy_start: got %b want 1", bus_if.busy); end
    bus_if.mc_output_ctrl = 5'b00001;
    set_lanes(32'h0001_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000);
    bus_if.lane_valid = 1'b1;
    repeat (8) tick();
    bus_if.lane_valid = 1'b0;
    n_cmp++; if (bus_if.price_valid !== 1'b0) begin n_err++; $display("FAIL single_pvld_early: got %b want 0", bus_if.price_valid); end
    n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL single_busy_finish: got %b want 1", bus_if.busy); end
    repeat (2) tick();
    n_cmp++; if (bus_if.price_out !== 32'h0001_0000) begin n_err++; $display("FAIL single_price: got %h want 00010000", bus_if.price_out); end
    n_cmp++; if (bus_if.price_valid !== 1'b1) begin n_err++; $display("FAIL single_pvld: got %b want 1", bus_if.price_valid); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_done: got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.short_run !== 1'b0) begin n_err++; $display("FAIL single_short: got %b want 0", bus_if.short_run); end
  endtask

  task automatic test_budget_cap();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    n_cmp++; if (bus_if.price_valid !== 1'b0) begin n_err++; $display("FAIL cap_pvld_clear: got %b want 0", bus_if.price_valid); end
    n_cmp++; if (bus_if.price_out !== 32'h0001_0000) begin n_err++; $display("FAIL cap_price_hold: got %h want 00010000", bus_if.price_out); end
    bus_if.mc_output_ctrl = 5'b11111;
    set_lanes(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000);
    bus_if.lane_valid = 1'b1;
    repeat (2) tick();
    bus_if.lane_valid = 1'b0;
    n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL cap_busy_finish: got %b want 1", bus_if.busy); end
    repeat (2) tick();
    n_cmp++; if (bus_if.price_out !== 32'h0002_A000) begin n_err++; $display("FAIL cap_price: got %h want 0002a000", bus_if.price_out); end
    n_cmp++; if (bus_if.price_valid !== 1'b1) begin n_err++; $display("FAIL cap_pvld: got %b want 1", bus_if.price_valid); end
    n_cmp++; if (bus_if.ctrl_err !== 1'b0) begin n_err++; $display("FAIL cap_err: got %b want 0", bus_if.ctrl_err); end
  endtask

  task automatic test_ctrl_err();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bus_if.mc_output_ctrl = 5'b00101;
    set_lanes(32'h0002_0000, 32'h7000_0000, 32'h0002_0000, 32'h7000_0000, 32'h7000_0000);
    bus_if.lane_valid = 1'b1;
    repeat (4) tick();
    bus_if.lane_valid = 1'b0;
    n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL err_busy_finish: got %b want 1", bus_if.busy); end
    repeat (2) tick();
    n_cmp++; if (bus_if.ctrl_err !== 1'b1) begin n_err++; $display("FAIL err_flag: got %b want 1", bus_if.ctrl_err); end
    n_cmp++; if (bus_if.price_out !== 32'h0002_0000) begin n_err++; $display("FAIL err_price: got %h want 00020000", bus_if.price_out); end
    n_cmp++; if (bus_if.price_valid !== 1'b1) begin n_err++; $display("FAIL err_pvld: got %b want 1", bus_if.price_valid); end
  endtask

  task automatic test_short_run();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    n_cmp++; if (bus_if.ctrl_err !== 1'b0) begin n_err++; $display("FAIL short_err_clear: got %b want 0", bus_if.ctrl_err); end
    bus_if.mc_output_ctrl = 5'b00001;
    set_lanes(32'h0002_0000, 32'h7000_0000, 32'h7000_0000, 32'h7000_0000, 32'h7000_0000);
    bus_if.lane_valid = 1'b1;
    repeat (4) tick();
    bus_if.lane_valid = 1'b0;
    n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL short_busy_accum: got %b want 1", bus_if.busy); end
    bus_if.engine_done = 1'b1;
    tick();
    bus_if.engine_done = 1'b0;
    n_cmp++; if (bus_if.short_run !== 1'b1) begin n_err++; $display("FAIL short_flag_early: got %b want 1", bus_if.short_run); end
    repeat (2) tick();
    n_cmp++; if (bus_if.price_out !== 32'h0001_0000) begin n_err++; $display("FAIL short_price: got %h want 00010000", bus_if.price_out); end
    n_cmp++; if (bus_if.price_valid !== 1'b1) begin n_err++; $display("FAIL short_pvld: got %b want 1", bus_if.price_valid); end
    n_cmp++; if (bus_if.short_run !== 1'b1) begin n_err++; $display("FAIL short_flag: got %b want 1", bus_if.short_run); end
    bus_if.engine_done = 1'b1;
    tick();
    bus_if.engine_done = 1'b0;
    tick();
    n_cmp++; if (bus_if.price_valid !== 1'b1) begin n_err++; $display("FAIL done_ignore_pvld: got %b want 1", bus_if.price_valid); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL done_ignore_busy: got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.price_out !== 32'h0001_0000) begin n_err++; $display("FAIL done_ignore_price: got %h want 00010000", bus_if.price_out); end
  endtask

  task automatic test_reset_mid_run();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bus_if.mc_output_ctrl = 5'b00001;
    set_lanes(32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0);
    bus_if.lane_valid = 1'b1;
    repeat (3) tick();
    bus_if.lane_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus_if.price_out !== 32'h0) begin n_err++; $display("FAIL midrst_price: got %h want 0", bus_if.price_out); end
    n_cmp++; if (bus_if.price_valid !== 1'b0) begin n_err++; $display("FAIL midrst_pvld: got %b want 0", bus_if.price_valid); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.short_run !== 1'b0) begin n_err++; $display("FAIL midrst_short: got %b want 0", bus_if.short_run); end
  endtask

  task automatic test_start_while_busy();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bus_if.mc_output_ctrl = 5'b00001;
    set_lanes(32'h0008_0000, 32'h0, 32'h0, 32'h0, 32'h0);
    bus_if.lane_valid = 1'b1;
    repeat (2) tick();
    bus_if.lane_valid = 1'b0;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    set_lanes(32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0);
    bus_if.lane_valid = 1'b1;
    repeat (6) tick();
    bus_if.lane_valid = 1'b0;
    repeat (2) tick();
    // 2*0x80000 + 6*0x10000 = 0x160000, divided by 8.
    n_cmp++; if (bus_if.price_valid !== 1'b1) begin n_err++; $display("FAIL busy_start_pvld: got %b want 1", bus_if.price_valid); end
    n_cmp++; if (bus_if.price_out !== 32'h0002_C000) begin n_err++; $display("FAIL busy_start_price: got %h want 0002c000", bus_if.price_out); end
    n_cmp++; if (bus_if.short_run !== 1'b0) begin n_err++; $display("FAIL busy_start_short: got %b want 0", bus_if.short_run); end
  endtask

  initial begin
    bus_if.start          = 1'b0;
    bus_if.mc_output_ctrl = '0;
    bus_if.engine_done    = 1'b0;
    bus_if.lane_valid     = 1'b0;
    bus_if.lane_payoff    = '0;
    test_reset();
    test_single_lane();
    test_budget_cap();
    test_ctrl_err();
    test_short_run();
    test_reset_mid_run();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
